// File: rtl/alu_shift_sequencer.sv
// Breaks a register-supplied shift (0-255) into single-cycle 4/2/1 ALU passes on source-B, stalling fetch until the last pass.
// Optional feature macro SHIFT_SAT_EN: amounts >= 8 saturate to 8 (passes 4,4) instead of wrapping mod 8.
module alu_shift_sequencer #(
    parameter int unsigned WB_CYCLES = 0,
    parameter logic [3:0]  IDLE_SRCB = 4'd0
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [7:0] ShiftAmt,
    input  logic       ShiftDir,
    output logic [3:0] ALUSrcBCtrl,
    output logic [1:0] instShamt,
    output logic       ShiftDirOut,
    output logic       PassValid,
    output logic       Busy,
    output logic       Done,
    output logic       Stall
);

`ifdef SHIFT_SAT_EN
    localparam int unsigned REM_W = 4;
`else
    localparam int unsigned REM_W = 3;
`endif
    localparam int unsigned WAIT_W = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;
    localparam logic [3:0] PASS_SRCB = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  remNext;
    logic [REM_W-1:0]  remSrc;
    logic [REM_W-1:0]  stepAmt;
    logic [REM_W-1:0]  effAmt;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              dirNext;
    logic              issue;
    logic [1:0]        stepCode;
    logic              accept;

    // Effective amount loaded into rem on accept
`ifdef SHIFT_SAT_EN
    assign effAmt = (ShiftAmt >= 8'd8) ? REM_W'(8) : REM_W'(ShiftAmt[2:0]);
`else
    logic unusedAmtBits;
    assign unusedAmtBits = ^ShiftAmt[7:3];
    assign effAmt        = ShiftAmt[2:0];
`endif

    assign accept = (state == IDLE) || (state == DONE);
    assign Stall  = Busy | (Start & accept);

    // Next-state, remaining amount and the pass (if any) issued at the coming edge
    always_comb begin
        nextState   = state;
        remNext     = rem;
        remSrc      = rem;
        waitCntNext = waitCnt;
        dirNext     = ShiftDirOut;
        issue       = 1'b0;
        stepCode    = 2'b00;
        stepAmt     = '0;

        case (state)
            IDLE, DONE: begin
                nextState = IDLE;
                if (Start) begin
                    dirNext = ShiftDir;
                    remSrc  = effAmt;
                    remNext = effAmt;
                    if (effAmt == '0) begin
                        nextState = DONE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            PASS: begin
                if (WB_CYCLES > 0) begin
                    nextState   = WAIT;
                    waitCntNext = WAIT_W'(WB_CYCLES - 1);
                end else if (rem == '0) begin
                    nextState = DONE;
                end else begin
                    issue = 1'b1;
                end
            end
            WAIT: begin
                if (waitCnt != '0) begin
                    waitCntNext = waitCnt - WAIT_W'(1);
                end else if (rem == '0) begin
                    nextState = DONE;
                end else begin
                    issue = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase

        // Largest step that still fits in the remaining amount
        if (issue) begin
            nextState = PASS;
            if (remSrc >= REM_W'(4)) begin
                stepCode = 2'b11;
                stepAmt  = REM_W'(4);
            end else if (remSrc >= REM_W'(2)) begin
                stepCode = 2'b10;
                stepAmt  = REM_W'(2);
            end else begin
                stepCode = 2'b01;
                stepAmt  = REM_W'(1);
            end
            remNext = remSrc - stepAmt;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            rem         <= '0;
            waitCnt     <= '0;
            ShiftDirOut <= 1'b0;
            ALUSrcBCtrl <= IDLE_SRCB;
            instShamt   <= 2'b00;
            PassValid   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state       <= nextState;
            rem         <= remNext;
            waitCnt     <= waitCntNext;
            ShiftDirOut <= dirNext;
            ALUSrcBCtrl <= issue ? PASS_SRCB : IDLE_SRCB;
            instShamt   <= stepCode;
            PassValid   <= issue;
            Busy        <= (nextState == PASS) || (nextState == WAIT);
            Done        <= (nextState == DONE);
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer: one instance with no writeback gap, one with a 2-cycle gap.
module tb_alu_shift_sequencer;

    localparam int unsigned W0    = 0;
    localparam int unsigned W1    = 2;
    localparam logic [3:0]  IDLE0 = 4'd0;
    localparam logic [3:0]  IDLE1 = 4'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, dir0, start1, dir1;
    logic [7:0] amt0, amt1;
    logic [3:0] srcB0, srcB1;
    logic [1:0] shamt0, shamt1;
    logic       dirOut0, dirOut1, pv0, pv1, busy0, busy1, done0, done1, stall0, stall1;

    always #5 clk = ~clk;

    alu_shift_sequencer #(.WB_CYCLES(W0), .IDLE_SRCB(IDLE0)) dut0 (
        .CLK(clk), .Reset_n(rst_n), .Start(start0), .ShiftAmt(amt0), .ShiftDir(dir0),
        .ALUSrcBCtrl(srcB0), .instShamt(shamt0), .ShiftDirOut(dirOut0), .PassValid(pv0),
        .Busy(busy0), .Done(done0), .Stall(stall0)
    );

    alu_shift_sequencer #(.WB_CYCLES(W1), .IDLE_SRCB(IDLE1)) dut1 (
        .CLK(clk), .Reset_n(rst_n), .Start(start1), .ShiftAmt(amt1), .ShiftDir(dir1),
        .ALUSrcBCtrl(srcB1), .instShamt(shamt1), .ShiftDirOut(dirOut1), .PassValid(pv1),
        .Busy(busy1), .Done(done1), .Stall(stall1)
    );

    typedef struct {
        int srcB;
        int shamt;
        int dirOut;
        int pv;
        int busy;
        int done;
        int stall;
    } obsT;

    typedef struct {
        int         which;
        logic [7:0] amt;
        logic       dir;
        int         expN;
        int         expDone;
    } vecT;

    int compared   = 0;
    int mismatched = 0;
    int mStep[$];

    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(int which, logic s, logic [7:0] a, logic d);
        if (which == 0) begin
            start0 = s; amt0 = a; dir0 = d;
        end else begin
            start1 = s; amt1 = a; dir1 = d;
        end
    endtask

    function automatic obsT sampleOut(int which);
        obsT o;
        if (which == 0) begin
            o.srcB = int'(srcB0); o.shamt = int'(shamt0); o.dirOut = int'(dirOut0);
            o.pv = int'(pv0); o.busy = int'(busy0); o.done = int'(done0); o.stall = int'(stall0);
        end else begin
            o.srcB = int'(srcB1); o.shamt = int'(shamt1); o.dirOut = int'(dirOut1);
            o.pv = int'(pv1); o.busy = int'(busy1); o.done = int'(done1); o.stall = int'(stall1);
        end
        return o;
    endfunction

    // Reference: greedy 4/2/1 decomposition of the effective amount
    task automatic buildModel(logic [7:0] amt);
        int r;
        mStep.delete();
`ifdef SHIFT_SAT_EN
        r = (amt >= 8'd8) ? 8 : int'(amt);
`else
        r = int'(amt) % 8;
`endif
        while (r > 0) begin
            int s;
            s = (r >= 4) ? 4 : ((r >= 2) ? 2 : 1);
            mStep.push_back(s);
            r -= s;
        end
    endtask

    task automatic checkReset(int which);
        obsT o;
        o = sampleOut(which);
        chk("rst_srcB", o.srcB, (which == 0) ? int'(IDLE0) : int'(IDLE1));
        chk("rst_shamt", o.shamt, 0);
        chk("rst_dirOut", o.dirOut, 0);
        chk("rst_pv", o.pv, 0);
        chk("rst_busy", o.busy, 0);
        chk("rst_done", o.done, 0);
        chk("rst_stall", o.stall, 0);
    endtask

    // Start a sequence in cycle 0 and check every following cycle against the model
    task automatic runSeq(int which, logic [7:0] amt, logic dir, int pulseAt, logic [7:0] pulseAmt,
                          output int nPass, output int doneAt);
        int         w;
        int         idle;
        int         n;
        int         doneCyc;
        obsT        o;
        w    = (which == 0) ? int'(W0) : int'(W1);
        idle = (which == 0) ? int'(IDLE0) : int'(IDLE1);
        buildModel(amt);
        n       = mStep.size();
        doneCyc = (n == 0) ? 1 : n * (w + 1) + 1;
        drive(which, 1'b1, amt, dir);
        #1;
        o = sampleOut(which);
        chk("stall_c0", o.stall, 1);
        @(posedge clk); #1;
        drive(which, 1'b0, amt, dir);
        nPass  = 0;
        doneAt = -1;
        for (int k = 1; k <= doneCyc + 1; k++) begin
            int idx;
            int code;
            int expBusy;
            bit pulsing;
            idx     = -1;
            pulsing = (k == pulseAt) && (k < doneCyc);
            if (pulsing) drive(which, 1'b1, pulseAmt, ~dir);
            #1;
            for (int i = 0; i < n; i++) begin
                if (1 + i * (w + 1) == k) idx = i;
            end
            code    = (idx < 0) ? 0 : ((mStep[idx] == 4) ? 3 : mStep[idx]);
            expBusy = (k < doneCyc) ? 1 : 0;
            o = sampleOut(which);
            chk("seq_pv", o.pv, (idx >= 0) ? 1 : 0);
            chk("seq_shamt", o.shamt, code);
            chk("seq_srcB", o.srcB, (idx >= 0) ? 1 : idle);
            chk("seq_busy", o.busy, expBusy);
            chk("seq_done", o.done, (k == doneCyc) ? 1 : 0);
            chk("seq_dirOut", o.dirOut, int'(dir));
            chk("seq_stall", o.stall, (expBusy != 0 || pulsing) ? 1 : 0);
            if (o.pv != 0) nPass++;
            if (o.done != 0) doneAt = k;
            @(posedge clk); #1;
            if (pulsing) drive(which, 1'b0, amt, dir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecT  vecs[9];
        obsT  o;
        int   n;
        int   d;

        vecs[0] = '{0, 8'd5,   1'b0, 2, 3};
        vecs[1] = '{0, 8'd7,   1'b1, 3, 4};
        vecs[2] = '{0, 8'd0,   1'b0, 0, 1};
`ifdef SHIFT_SAT_EN
        vecs[3] = '{0, 8'd12,  1'b0, 2, 3};
        vecs[8] = '{0, 8'd255, 1'b1, 2, 3};
`else
        vecs[3] = '{0, 8'd12,  1'b0, 1, 2};
        vecs[8] = '{0, 8'd255, 1'b1, 3, 4};
`endif
        vecs[4] = '{1, 8'd3,   1'b1, 2, 7};
        vecs[5] = '{0, 8'd1,   1'b0, 1, 2};
        vecs[6] = '{1, 8'd2,   1'b0, 1, 4};
        vecs[7] = '{1, 8'd6,   1'b1, 2, 7};

        rst_n = 1'b0;
        drive(0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 8'd0, 1'b0);
        #12;
        checkReset(0);
        checkReset(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            runSeq(vecs[v].which, vecs[v].amt, vecs[v].dir, 0, 8'd0, n, d);
            chk("tbl_npass", n, vecs[v].expN);
            chk("tbl_done", d, vecs[v].expDone);
        end

        // Start pulsed mid-PASS is ignored and not queued
        runSeq(0, 8'd7, 1'b1, 2, 8'd1, n, d);
        chk("ign_npass", n, 3);
        chk("ign_done", d, 4);
        o = sampleOut(0);
        chk("ign_idle_pv", o.pv, 0);

        // Start held through DONE restarts back-to-back
        drive(0, 1'b1, 8'd1, 1'b0);
        #1;
        o = sampleOut(0);
        chk("b2b_stall_c0", o.stall, 1);
        @(posedge clk); #1;
        o = sampleOut(0);
        chk("b2b_pv1", o.pv, 1);
        chk("b2b_shamt1", o.shamt, 1);
        chk("b2b_stall1", o.stall, 1);
        @(posedge clk); #1;
        o = sampleOut(0);
        chk("b2b_done2", o.done, 1);
        chk("b2b_busy2", o.busy, 0);
        chk("b2b_stall2", o.stall, 1);
        drive(0, 1'b1, 8'd2, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd2, 1'b1);
        #1;
        o = sampleOut(0);
        chk("b2b_pv3", o.pv, 1);
        chk("b2b_shamt3", o.shamt, 2);
        chk("b2b_dir3", o.dirOut, 1);
        @(posedge clk); #1;
        o = sampleOut(0);
        chk("b2b_done4", o.done, 1);
        chk("b2b_stall4", o.stall, 0);
        @(posedge clk); #1;
        o = sampleOut(0);
        chk("b2b_done5", o.done, 0);
        chk("b2b_pv5", o.pv, 0);

        // Reset during WAIT abandons the sequence without Done
        drive(1, 1'b1, 8'd3, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'd3, 1'b1);
        o = sampleOut(1);
        chk("rw_pv1", o.pv, 1);
        @(posedge clk); #1;
        o = sampleOut(1);
        chk("rw_busy2", o.busy, 1);
        chk("rw_pv2", o.pv, 0);
        rst_n = 1'b0;
        #1;
        checkReset(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            o = sampleOut(1);
            chk("rw_post_done", o.done, 0);
            chk("rw_post_pv", o.pv, 0);
            chk("rw_post_busy", o.busy, 0);
        end

        // Randomized sequences on both instances
        for (int r = 0; r < 40; r++) begin
            int         which;
            logic [7:0] amt;
            logic       dir;
            which = int'($urandom_range(0, 1));
            amt   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            dir   = 1'($urandom_range(0, 1));
            runSeq(which, amt, dir, int'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), n, d);
            chk("rnd_npass", n, mStep.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle controller that turns a shift by a register-supplied amount (0–255) into a sequence of single-cycle ALU passes. Each pass uses one of the fixed source-B shift encodings (1, 2 or 4). It sits between the decoder and the ALU source-B mux. While it is active it owns the source-B select and shamt lines, and it stalls fetch until the last pass has been issued.

## Interface
Parameters:
- `WB_CYCLES`, default 0: idle cycles inserted after each pass so the ALU result can be written back before the next pass reads it.
- `IDLE_SRCB`, default 4'd0: source-B select driven when no pass is active (register operand).

Ports (clock and reset first):
- `CLK` in 1: single clock. All state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: request a shift. Sampled on `CLK`.
- `ShiftAmt` in 8: shift amount, latched when `Start` is accepted.
- `ShiftDir` in 1: 0 = left, 1 = right. Latched with `ShiftAmt`.
- `ALUSrcBCtrl` out 4: source-B select. Value 4'd1 during a pass, `IDLE_SRCB` otherwise.
- `instShamt` out 2: shamt code. 2'b11 = 4, 2'b10 = 2, 2'b01 = 1, 2'b00 when no pass.
- `ShiftDirOut` out 1: latched direction, for ALU op select.
- `PassValid` out 1: high for exactly the cycle a pass is issued. Doubles as the writeback enable.
- `Busy` out 1: high in PASS and WAIT.
- `Done` out 1: one-cycle pulse when the sequence completes.
- `Stall` out 1: combinational. Equals `Busy | (Start & accept)`.

## Operation
- States: IDLE, PASS, WAIT, DONE. Registered remaining-amount `rem` is 4 bits (0–8).
- Start is accepted in IDLE or DONE. In PASS or WAIT, `Start` is ignored and is not queued.
- On accept:
  - `rem` is loaded with the effective amount (see Configuration). The direction is latched.
  - If `rem` is 0, go to DONE. Otherwise go to PASS.
- PASS, largest step first:
  - If `rem` ≥ 4: shamt = 4, `rem` −= 4.
  - Else if `rem` ≥ 2: shamt = 2, `rem` −= 2.
  - Else: shamt = 1, `rem` −= 1.
- PASS drives `ALUSrcBCtrl` = 1, the shamt code, and `PassValid` = 1.
- Leaving PASS:
  - If `WB_CYCLES` > 0, go to WAIT.
  - Else if the new `rem` is 0, go to DONE.
  - Else stay in PASS.
- WAIT lasts exactly `WB_CYCLES` cycles, counted by a wait counter. It then goes to PASS, or to DONE if `rem` is 0.
- DONE lasts one cycle with `Done` = 1. It returns to IDLE, or to IDLE-equivalent accept if `Start` is high, giving back-to-back operation.
- Pass counts by amount: 1, 2, 4 → 1 pass; 3, 5, 6 → 2 passes; 7 → 3 passes.
- Outputs are registered, except `Stall`.

## Timing
- Reset (asynchronous, `Reset_n` = 0):
  - State goes to IDLE.
  - `ALUSrcBCtrl` = `IDLE_SRCB`, `instShamt` = 0, `ShiftDirOut` = 0.
  - `PassValid` = 0, `Busy` = 0, `Done` = 0, `rem` = 0.
- Reset asserted mid-sequence abandons the sequence. No `Done` is issued.
- Start accepted at edge 0:
  - First pass is visible in cycle 1.
  - With N passes and `WB_CYCLES` = W, the last pass is in cycle 1 + (N−1)(W+1).
  - `Done` follows in the next cycle after the last pass, plus W.
- Amount 0: `Done` in cycle 1. No `PassValid`.
- `Stall` rises in the same cycle `Start` is accepted. It falls in the DONE cycle.

## Configuration
- `SHIFT_SAT_EN` defined:
  - Amounts ≥ 8 load `rem` = 8, giving passes 4, 4.
  - A logical 8-bit shift result is therefore zero.
- `SHIFT_SAT_EN` undefined:
  - Effective amount is `ShiftAmt[2:0]` (mod 8).
  - `rem` needs only 3 bits.

## Test plan
- `ShiftAmt` = 5, W = 0, Start at edge 0:
  - Cycle 1: `PassValid`, shamt code 2'b11.
  - Cycle 2: shamt code 2'b01.
  - Cycle 3: `Done` = 1. `Busy` is low from cycle 3.
- `ShiftAmt` = 7, `ShiftDir` = 1:
  - Shamt codes 11, 10, 01 in cycles 1–3, with `ShiftDirOut` = 1 throughout.
  - `Done` in cycle 4.
- `ShiftAmt` = 0: `Done` in cycle 1. `PassValid` never asserts. `ALUSrcBCtrl` stays `IDLE_SRCB`.
- `ShiftAmt` = 12:
  - With `SHIFT_SAT_EN`: codes 11, 11, then `Done` in cycle 3.
  - Without: single code 11, then `Done` in cycle 2.
- W = 2, `ShiftAmt` = 3:
  - Passes in cycles 1 and 4.
  - `Done` in cycle 7.
  - `Stall` is high for cycles 0–6.
- Robustness, in three parts:
  - `Start` pulsed during PASS is ignored.
  - `Start` held high through DONE immediately starts a new sequence.
  - `Reset_n` dropped in a WAIT cycle immediately returns all outputs to reset values, with no `Done`.
